// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants and types for the hardwired control sequencer of the
// 1-bus datapath: opcode values, ALU function selects, the step (state)
// encoding exposed on the "step" port, the decoded instruction class and
// the bundle of one-bit datapath control strobes.
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Opcode field values (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;

    // ALU function selects
    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd3;

    // Step encoding; the numeric values are visible on the step output
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } step_e;

    // Decoded instruction class
    typedef enum logic [2:0] {
        INS_LD   = 3'd0,
        INS_LDI  = 3'd1,
        INS_ST   = 3'd2,
        INS_ADDI = 3'd3,
        INS_ILL  = 3'd4
    } instr_e;

    // One-bit datapath control strobes
    typedef struct packed {
        logic pcout;
        logic zlowout;
        logic mdrout;
        logic cout;
        logic baout;
        logic rout;
        logic marin;
        logic zin;
        logic pcin;
        logic mdrin;
        logic irin;
        logic yin;
        logic rin;
        logic incpc;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
    } ctrl_t;

    // Map an opcode onto its instruction class; anything not listed is illegal.
    function automatic instr_e decode_op(input logic [4:0] op);
        instr_e res;
        case (op)
            OP_LD:   res = INS_LD;
            OP_LDI:  res = INS_LDI;
            OP_ST:   res = INS_ST;
            OP_ADDI: res = INS_ADDI;
            default: res = INS_ILL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive not-ready cycles of a memory (or I/O) handshake and
// flags a timeout once TIMEOUT such cycles have elapsed without ready.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   clear    in   synchronous active-high reset
//   active   in   a handshake wait step is in progress
//   ready    in   the far side completed the transfer
//   count    out  number of not-ready cycles seen in the current step
//   timeout  out  this is the TIMEOUT-th consecutive not-ready cycle
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             active,
    input  logic             ready,
    output logic [CNT_W-1:0] count,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (active && !ready) begin
            // count already holds TIMEOUT-1 earlier misses, so this miss is the last allowed
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                timeout = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // any cycle that is not a stalled wait (ready seen, or step left) restarts the count
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/ldst_control_sequencer.sv
// ----------------------------------------------------------------------------
// ldst_control_sequencer
// Hardwired control-step generator for the 1-bus datapath. Runs the fetch
// steps T0..T2 and the execute steps for ld, ldi, st and addi, with a
// memory-ready handshake (bounded by MEM_TIMEOUT), run gating between
// instructions and a sticky HALT on an illegal opcode or memory timeout.
//
// Ports:
//   clk                                in   clock, all state on rising edge
//   clear                              in   synchronous active-high reset
//   run                                in   permit a new fetch from IDLE / instruction end
//   ir_opcode[OPCODE_W-1:0]            in   IR opcode field, valid from T3 onward
//   mem_ready                          in   memory completed current Read/Write
//   PCout Zlowout MDRout Cout BAout Rout  out  bus drivers
//   MARin Zin PCin MDRin IRin Yin Rin     out  register loads
//   IncPC Read Write Gra Grb Grc          out  PC increment, memory strobes, reg select
//   alu_op[ALUOP_W-1:0]                out  ALU function (ADD in T0/T4, else NOP)
//   step[3:0]                          out  current step encoding
//   done                               out  pulse in the last step of an instruction
//   illegal                            out  sticky: undecoded opcode seen
//   mem_fault                          out  sticky: mem_ready timeout
// ----------------------------------------------------------------------------
module ldst_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                Cout,
    output logic                BAout,
    output logic                Rout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Rin,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [3:0]          step,
    output logic                done,
    output logic                illegal,
    output logic                mem_fault
);

    step_e            state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             mem_fault_q, mem_fault_d;

    instr_e           ins;
    ctrl_t            ctl;
    logic             wait_active;
    logic             tmo_hit;
    logic [TMO_W-1:0] tmo_count;

    // Opcode constants are 5 bits wide; the field is resized to match them.
    assign ins = decode_op(5'(ir_opcode));

    // Steps that stall on mem_ready: instruction fetch, ld data read, st write.
    assign wait_active = (state_q == S_T1)
                      || ((state_q == S_T6) && (ins == INS_LD))
                      || ((state_q == S_T7) && (ins == INS_ST));

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT),
        .CNT_W   (TMO_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .clear   (clear),
        .active  (wait_active),
        .ready   (mem_ready),
        .count   (tmo_count),
        .timeout (tmo_hit)
    );

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        mem_fault_d = mem_fault_q;
        ctl         = '0;
        alu_op      = ALUOP_W'(ALU_NOP);
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T0;
                end
            end

            S_T0: begin
                ctl.pcout = 1'b1;
                ctl.marin = 1'b1;
                ctl.incpc = 1'b1;
                ctl.zin   = 1'b1;
                alu_op    = ALUOP_W'(ALU_ADD);
                state_d   = S_T1;
            end

            S_T1: begin
                ctl.zlowout = 1'b1;
                ctl.read    = 1'b1;
                ctl.mdrin   = 1'b1;
                // a zero miss count marks the first T1 cycle; a stall must not reload PC
                ctl.pcin    = (tmo_count == '0);
                if (tmo_hit) begin
                    mem_fault_d = 1'b1;
                    state_d     = S_HALT;
                end else if (mem_ready) begin
                    state_d = S_T2;
                end
            end

            S_T2: begin
                ctl.mdrout = 1'b1;
                ctl.irin   = 1'b1;
                state_d    = S_T3;
            end

            S_T3: begin
                case (ins)
                    INS_LD, INS_LDI, INS_ST: begin
                        ctl.grb   = 1'b1;
                        ctl.baout = 1'b1;
                        ctl.yin   = 1'b1;
                        state_d   = S_T4;
                    end
                    INS_ADDI: begin
                        ctl.grb  = 1'b1;
                        ctl.rout = 1'b1;
                        ctl.yin  = 1'b1;
                        state_d  = S_T4;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end

            S_T4: begin
                ctl.cout = 1'b1;
                ctl.zin  = 1'b1;
                alu_op   = ALUOP_W'(ALU_ADD);
                state_d  = S_T5;
            end

            S_T5: begin
                ctl.zlowout = 1'b1;
                if ((ins == INS_LD) || (ins == INS_ST)) begin
                    // effective address goes to MAR for the data access
                    ctl.marin = 1'b1;
                    state_d   = S_T6;
                end else begin
                    ctl.gra = 1'b1;
                    ctl.rin = 1'b1;
                    done    = 1'b1;
                    state_d = run ? S_T0 : S_IDLE;
                end
            end

            S_T6: begin
                if (ins == INS_LD) begin
                    ctl.read  = 1'b1;
                    ctl.mdrin = 1'b1;
                    if (tmo_hit) begin
                        mem_fault_d = 1'b1;
                        state_d     = S_HALT;
                    end else if (mem_ready) begin
                        state_d = S_T7;
                    end
                end else begin
                    // st: Read stays low so MDR captures the register from the bus
                    ctl.gra   = 1'b1;
                    ctl.rout  = 1'b1;
                    ctl.mdrin = 1'b1;
                    state_d   = S_T7;
                end
            end

            S_T7: begin
                if (ins == INS_LD) begin
                    ctl.mdrout = 1'b1;
                    ctl.gra    = 1'b1;
                    ctl.rin    = 1'b1;
                    done       = 1'b1;
                    state_d    = run ? S_T0 : S_IDLE;
                end else begin
                    ctl.write = 1'b1;
                    if (tmo_hit) begin
                        mem_fault_d = 1'b1;
                        state_d     = S_HALT;
                    end else if (mem_ready) begin
                        done    = 1'b1;
                        state_d = run ? S_T0 : S_IDLE;
                    end
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                // unused encodings are treated as a fault condition
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_IDLE;
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign PCout     = ctl.pcout;
    assign Zlowout   = ctl.zlowout;
    assign MDRout    = ctl.mdrout;
    assign Cout      = ctl.cout;
    assign BAout     = ctl.baout;
    assign Rout      = ctl.rout;
    assign MARin     = ctl.marin;
    assign Zin       = ctl.zin;
    assign PCin      = ctl.pcin;
    assign MDRin     = ctl.mdrin;
    assign IRin      = ctl.irin;
    assign Yin       = ctl.yin;
    assign Rin       = ctl.rin;
    assign IncPC     = ctl.incpc;
    assign Read      = ctl.read;
    assign Write     = ctl.write;
    assign Gra       = ctl.gra;
    assign Grb       = ctl.grb;
    assign Grc       = ctl.grc;
    assign step      = state_q;
    assign illegal   = illegal_q;
    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ldst_control_sequencer
// The reference model describes each instruction as the list of cycles it
// should occupy (step, strobes, inputs to drive) given how long memory stalls
// in each wait step; directed and random instructions are expanded into one
// vector table that is then replayed cycle by cycle against the DUT.
// ----------------------------------------------------------------------------
module tb_ldst_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int TMO = 15;

    localparam logic [3:0] L_IDLE = 4'd0;
    localparam logic [3:0] L_T0   = 4'd1;
    localparam logic [3:0] L_T1   = 4'd2;
    localparam logic [3:0] L_T2   = 4'd3;
    localparam logic [3:0] L_T3   = 4'd4;
    localparam logic [3:0] L_T4   = 4'd5;
    localparam logic [3:0] L_T5   = 4'd6;
    localparam logic [3:0] L_T6   = 4'd7;
    localparam logic [3:0] L_T7   = 4'd8;
    localparam logic [3:0] L_HALT = 4'd15;

    typedef struct packed {
        logic pcout, zlowout, mdrout, cout, baout, rout, marin, zin, pcin, mdrin;
        logic irin, yin, rin, incpc, read, write, gra, grb, grc, done;
    } ctl_t;

    typedef struct {
        logic       clear;
        logic       run;
        logic       mr;
        logic [4:0] opc;
        logic [3:0] step;
        ctl_t       ctl;
        logic [4:0] alu;
        logic       ill;
        logic       flt;
    } vec_t;

    logic       clk;
    logic       clear, run, mem_ready;
    logic [4:0] ir_opcode;
    logic       PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, Zin, PCin, MDRin;
    logic       IRin, Yin, Rin, IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0] alu_op;
    logic [3:0] step;
    logic       done, illegal, mem_fault;

    ldst_control_sequencer #(
        .OPCODE_W(5), .ALUOP_W(5), .MEM_TIMEOUT(TMO), .TMO_W(4)
    ) dut (
        .clk(clk), .clear(clear), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
        .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Rin(Rin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .alu_op(alu_op), .step(step), .done(done),
        .illegal(illegal), .mem_fault(mem_fault)
    );

    ctl_t dut_ctl;
    assign dut_ctl = {PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, Zin, PCin, MDRin,
                      IRin, Yin, Rin, IncPC, Read, Write, Gra, Grb, Grc, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vq[$];
    int   nvec = 0;
    int   nmis = 0;
    bit   m_idle, m_ill, m_flt;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [4:0] ro();
        return 5'($urandom);
    endfunction

    function automatic void push(logic [3:0] st, ctl_t c, logic add, logic mr, logic rn,
                                 logic [4:0] opc);
        vec_t v;
        v.clear = 1'b0;
        v.run   = rn;
        v.mr    = mr;
        v.opc   = opc;
        v.step  = st;
        v.ctl   = c;
        v.alu   = add ? ALU_ADD : ALU_NOP;
        v.ill   = m_ill;
        v.flt   = m_flt;
        vq.push_back(v);
    endfunction

    function automatic void add_idle(int n);
        ctl_t c = '0;
        for (int i = 0; i < n; i++) push(L_IDLE, c, 1'b0, rb(), 1'b0, ro());
        m_idle = 1'b1;
    endfunction

    // Machine sits in HALT regardless of inputs until clear is applied.
    function automatic void halt_and_clear();
        ctl_t c = '0;
        for (int i = 0; i < 3; i++) push(L_HALT, c, 1'b0, rb(), rb(), ro());
        vq[vq.size()-1].clear = 1'b1;
        m_ill  = 1'b0;
        m_flt  = 1'b0;
        m_idle = 1'b1;
    endfunction

    // Expected cycles of one instruction; wN = not-ready cycles in that wait step.
    function automatic void gen_instr(logic [4:0] op, int w1, int w6, int w7,
                                      logic run_after, bit clr_t4);
        ctl_t c;
        bit is_ld   = (op == OP_LD);
        bit is_st   = (op == OP_ST);
        bit is_addi = (op == OP_ADDI);
        bit legal   = is_ld || is_st || is_addi || (op == OP_LDI);
        if (m_idle) begin
            c = '0;
            push(L_IDLE, c, 1'b0, rb(), 1'b1, ro());
        end
        m_idle = 1'b0;
        c = '0; c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1;
        push(L_T0, c, 1'b1, rb(), 1'b1, ro());
        for (int k = 0; k <= w1 && k < TMO; k++) begin
            c = '0; c.zlowout = 1; c.read = 1; c.mdrin = 1; c.pcin = (k == 0);
            push(L_T1, c, 1'b0, (k == w1), rb(), ro());
        end
        if (w1 >= TMO) begin m_flt = 1'b1; halt_and_clear(); return; end
        c = '0; c.mdrout = 1; c.irin = 1;
        push(L_T2, c, 1'b0, rb(), rb(), ro());
        c = '0;
        if (legal) begin
            c.grb = 1; c.yin = 1;
            if (is_addi) c.rout = 1; else c.baout = 1;
        end
        push(L_T3, c, 1'b0, rb(), rb(), op);
        if (!legal) begin m_ill = 1'b1; halt_and_clear(); return; end
        c = '0; c.cout = 1; c.zin = 1;
        push(L_T4, c, 1'b1, rb(), rb(), op);
        if (clr_t4) begin vq[vq.size()-1].clear = 1'b1; m_idle = 1'b1; return; end
        if (!is_ld && !is_st) begin
            c = '0; c.zlowout = 1; c.gra = 1; c.rin = 1; c.done = 1;
            push(L_T5, c, 1'b0, rb(), run_after, op);
            m_idle = !run_after;
            return;
        end
        c = '0; c.zlowout = 1; c.marin = 1;
        push(L_T5, c, 1'b0, rb(), rb(), op);
        if (is_ld) begin
            for (int k = 0; k <= w6 && k < TMO; k++) begin
                c = '0; c.read = 1; c.mdrin = 1;
                push(L_T6, c, 1'b0, (k == w6), rb(), op);
            end
            if (w6 >= TMO) begin m_flt = 1'b1; halt_and_clear(); return; end
            c = '0; c.mdrout = 1; c.gra = 1; c.rin = 1; c.done = 1;
            push(L_T7, c, 1'b0, rb(), run_after, op);
        end else begin
            c = '0; c.gra = 1; c.rout = 1; c.mdrin = 1;
            push(L_T6, c, 1'b0, rb(), rb(), op);
            for (int k = 0; k <= w7 && k < TMO; k++) begin
                c = '0; c.write = 1; c.done = (k == w7);
                push(L_T7, c, 1'b0, (k == w7), (k == w7) ? run_after : rb(), op);
            end
            if (w7 >= TMO) begin m_flt = 1'b1; halt_and_clear(); return; end
        end
        m_idle = !run_after;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rop;
        int         sel, wsel[3];
        logic       ra;

        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir_opcode = 5'd0;
        m_idle = 1'b1; m_ill = 1'b0; m_flt = 1'b0;

        // Directed vectors from the test plan
        add_idle(2);                                   // reset state
        gen_instr(OP_LDI, 0, 0, 0, 1'b0, 1'b0);        // ldi, no waits
        add_idle(1);
        gen_instr(OP_LD, 3, 2, 0, 1'b1, 1'b0);         // ld with T1/T6 stalls
        gen_instr(OP_ST, 0, 0, 5, 1'b0, 1'b0);         // st with T7 stall
        gen_instr(OP_ST, TMO-1, 0, TMO-1, 1'b1, 1'b0); // longest stall that still succeeds
        gen_instr(OP_LD, TMO, 0, 0, 1'b0, 1'b0);       // mem_ready stuck low in T1
        gen_instr(5'b11111, 0, 0, 0, 1'b0, 1'b0);      // illegal opcode
        gen_instr(OP_ADDI, 0, 0, 0, 1'b0, 1'b1);       // clear during T4
        add_idle(3);
        gen_instr(OP_LD, 0, TMO, 0, 1'b0, 1'b0);       // timeout in T6
        gen_instr(OP_ST, 0, 0, TMO, 1'b0, 1'b0);       // timeout in T7

        // Random instruction mix
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 9: rop = OP_LD;
                2, 3:    rop = OP_LDI;
                4, 5:    rop = OP_ST;
                6, 7:    rop = OP_ADDI;
                default: rop = ro();
            endcase
            for (int j = 0; j < 3; j++)
                wsel[j] = ($urandom_range(0, 24) == 0) ? TMO + $urandom_range(0, 2)
                                                       : $urandom_range(0, 3);
            ra = rb();
            gen_instr(rop, wsel[0], wsel[1], wsel[2], ra, 1'b0);
            if (!ra) add_idle($urandom_range(0, 2));
        end

        repeat (2) @(posedge clk);

        // Replay the table: drive inputs at negedge, compare the decode 1 time unit later
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            clear     = vq[i].clear;
            run       = vq[i].run;
            mem_ready = vq[i].mr;
            ir_opcode = vq[i].opc;
            #1;
            nvec++;
            if ({step, dut_ctl, alu_op, illegal, mem_fault} !==
                {vq[i].step, vq[i].ctl, vq[i].alu, vq[i].ill, vq[i].flt}) begin
                nmis++;
                $display("FAIL vec%0d: got step=%0d ctl=%h alu=%0d ill=%b flt=%b expected step=%0d ctl=%h alu=%0d ill=%b flt=%b",
                         i, step, dut_ctl, alu_op, illegal, mem_fault,
                         vq[i].step, vq[i].ctl, vq[i].alu, vq[i].ill, vq[i].flt);
            end
        end

        // Hand sequence: clear while stalled in T1 of a ld
        @(negedge clk);
        clear = 1'b0; run = 1'b1; mem_ready = 1'b0; ir_opcode = OP_LD;
        for (int i = 0; i < 10 && step != L_T1; i++) @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("stall_step", 32'(step), 32'(L_T1));
        chk("stall_read_pcin", {30'd0, Read, PCin}, 32'b10);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_step", 32'(step), 32'(L_IDLE));
        chk("clr_ctl", 32'(dut_ctl), 32'd0);
        chk("clr_flags", {30'd0, illegal, mem_fault}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("idle_hold", 32'(step), 32'(L_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
